// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank.
// Exposes C_NUM_REGS read/write registers of C_S_AXI_DATA_WIDTH bits behind an
// AXI4-Lite slave port. Write address and write data are captured independently
// into holding registers, committed one cycle after both are held, and answered
// on B. Reads return registered data one cycle after the AR handshake.
// Ports:
//   s_axi_aclk, s_axi_aresetn      clock (rising edge), async active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b*    write address, write data, write response
//   s_axi_ar*/s_axi_r*             read address, read data/response
//   reg_out                        flat register contents, reg i at [i*DW +: DW]
//   reg_wr_pulse                   one-cycle strobe per register on a committed write
module axi4lite_regbank #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_REGS         = 4
) (
  input  logic                                     s_axi_aclk,
  input  logic                                     s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic                                     s_axi_awvalid,
  output logic                                     s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                                     s_axi_wvalid,
  output logic                                     s_axi_wready,
  output logic [1:0]                               s_axi_bresp,
  output logic                                     s_axi_bvalid,
  input  logic                                     s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic                                     s_axi_arvalid,
  output logic                                     s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                               s_axi_rresp,
  output logic                                     s_axi_rvalid,
  input  logic                                     s_axi_rready,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W   = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = AW - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}           r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;

  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q,  w_full_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic [DW-1:0]         w_data_q,  w_data_d;
  logic [STRB_W-1:0]     w_strb_q,  w_strb_d;

  logic                  awready_d, wready_d, arready_d;
  logic                  bvalid_d;
  logic [1:0]            bresp_d;
  logic [C_NUM_REGS-1:0] pulse_d;
  logic                  rvalid_d;
  logic [1:0]            rresp_d;
  logic [DW-1:0]         rdata_d;

  logic [DW-1:0]         regs_q [C_NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_idx_ok, rd_idx_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [DW-1:0]         rd_word;
  logic                  addr_unused;

  // Byte-offset address bits carry no information for word registers.
  assign addr_unused = ^{s_axi_awaddr, s_axi_araddr};

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid  && s_axi_wready;
  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign wr_idx_ok = 32'(aw_idx_q) < C_NUM_REGS;
  assign rd_idx    = s_axi_araddr[AW-1:ADDR_LSB];
  assign rd_idx_ok = 32'(rd_idx) < C_NUM_REGS;

  // Read mux; out-of-range indices return zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      if (32'(rd_idx) == i) rd_word = regs_q[i];
    end
  end

  // ---------------------------------------------------------------- write FSM
  // State and holding registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

  // Next state: collect AW and W in any order, commit, then wait for bready.
  always_comb begin
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[AW-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb;
        end
        if (aw_full_d && w_full_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: w_state_d = W_RESP;
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Next values of the registered write-side outputs.
  always_comb begin
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    pulse_d   = '0;
    awready_d = (w_state_d == W_IDLE) && !aw_full_d;
    wready_d  = (w_state_d == W_IDLE) && !w_full_d;
    if (w_state_q == W_COMMIT) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_idx_ok ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
        pulse_d[i] = (32'(aw_idx_q) == i);
      end
    end else if ((w_state_q == W_RESP) && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      reg_wr_pulse  <= '0;
    end else begin
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      reg_wr_pulse  <= pulse_d;
    end
  end

  // Register file: byte-masked update on the commit edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else if (w_state_q == W_COMMIT) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
        if (32'(aw_idx_q) == i) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < int'(C_NUM_REGS); g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state_q <= R_IDLE;
    else                r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs)        r_state_d = R_DATA;
      R_DATA:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Data and response are captured on the AR handshake and held until rready.
  always_comb begin
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    rvalid_d  = (r_state_d == R_DATA);
    arready_d = (r_state_d == R_IDLE);
    if ((r_state_q == R_IDLE) && ar_hs) begin
      rdata_d = rd_word;
      rresp_d = rd_idx_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rresp   <= rresp_d;
      s_axi_rdata   <= rdata_d;
    end
  end

endmodule

// File: doc/axi4lite_regbank.md
AXI4LITE_REGBANK -- requirements
Module: axi4lite_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (8/16/32).
REQ-003 SHALL have parameter C_NUM_REGS, default 4, register count (1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: s_axi_aclk and s_axi_aresetn.
REQ-005 s_axi_aclk  in  1  clock, rising edge.
REQ-006 s_axi_aresetn  in  1  async active-low reset.
REQ-007 s_axi_awaddr/s_axi_awvalid  in  ADDR_WIDTH/1  write address, valid; s_axi_awready  out  1.
REQ-008 s_axi_wdata/s_axi_wstrb/s_axi_wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  write data, byte strobes, valid; s_axi_wready  out  1.
REQ-009 s_axi_bresp/s_axi_bvalid  out  2/1  write response; s_axi_bready  in  1.
REQ-010 s_axi_araddr/s_axi_arvalid  in  ADDR_WIDTH/1  read address, valid; s_axi_arready  out  1.
REQ-011 s_axi_rdata/s_axi_rresp/s_axi_rvalid  out  DATA_WIDTH/2/1  read data, response; s_axi_rready  in  1.
REQ-012 reg_out  out  C_NUM_REGS*DATA_WIDTH  flat register contents, reg i at bits [i*DW +: DW].
REQ-013 reg_wr_pulse  out  C_NUM_REGS  one-cycle strobe per register on committed write.

Function
REQ-014 Word index SHALL be addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-015 Write path SHALL capture AW and W independently into holding registers; either may arrive first or together.
REQ-016 s_axi_awready SHALL be 1 iff AW holding empty and bvalid=0; s_axi_wready likewise for W holding.
REQ-017 Write FSM states: W_IDLE (collecting AW/W), W_COMMIT (both held), W_RESP (bvalid=1).
REQ-018 W_IDLE->W_COMMIT on the edge where both holdings become full; W_COMMIT->W_RESP next edge, committing write, pulsing reg_wr_pulse[idx], setting bvalid.
REQ-019 Commit SHALL update only bytes with wstrb[b]=1; wstrb=0 commits nothing but returns OKAY.
REQ-020 Index >= C_NUM_REGS SHALL not modify any register, no reg_wr_pulse, bresp=2'b10 (SLVERR); else 2'b00.
REQ-021 W_RESP SHALL hold bvalid/bresp stable until bready=1 at an edge, then clear holdings and return to W_IDLE.
REQ-022 Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1, arready=0).
REQ-023 On AR handshake edge, rdata/rresp SHALL be registered and rvalid=1 from that edge (1-cycle latency).
REQ-024 Read index >= C_NUM_REGS SHALL return rdata=0, rresp=2'b10.
REQ-025 R_DATA SHALL hold rdata/rresp/rvalid stable until rready=1 at an edge, then return to R_IDLE.
REQ-026 Read and write channels SHALL operate concurrently; a read sampling the same register on the commit edge returns the pre-write value.
REQ-027 reg_out SHALL reflect register contents continuously (registered, updated on commit edge).

Reset
REQ-028 On aresetn=0, asynchronously: all registers=0, FSMs to W_IDLE/R_IDLE, holdings empty, bvalid=rvalid=0, bresp=rresp=0, rdata=0, reg_wr_pulse=0; awready/wready/arready=1 one cycle after deassertion.
REQ-029 Reset mid-transaction SHALL abandon it with no register modification and no response after release.

Verification
REQ-030 AW and W same cycle, addr 0x4, data 0xA5A5A5A5, strb 0xF -> bvalid 2 edges after handshake, bresp=00, reg_out[63:32]=0xA5A5A5A5, reg_wr_pulse=4'b0010 one cycle.
REQ-031 W 3 cycles before AW, addr 0x0, data 0x11223344, strb 0x5 on zero reg -> reg0=0x00220044; wready=0 while W held.
REQ-032 Write addr 0xC with C_NUM_REGS=3 -> bresp=10, no reg change, no pulse; read addr 0xC -> rdata=0, rresp=10.
REQ-033 bready held 0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; rready=0 likewise holds rdata.
REQ-034 Read reg1 on its commit edge -> old value returned; next read returns new value.
REQ-035 aresetn pulsed low with AW held, W pending -> all outputs reset values, no bvalid after release, reg_out=0.
